// File: rtl/mem_port_arbiter_if.sv
// One memory port: request/write payload toward the slave, grant and
// read response back toward the master.
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic [DATA_WIDTH-1:0] addr;
  logic                  we;
  logic [DATA_WIDTH-1:0] wdata;
  logic [3:0]            wstrb;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  // Requester side of the port
  modport master (
    output req, addr, we, wdata, wstrb,
    input  gnt, rvalid, rdata
  );

  // Responder side of the port
  modport slave (
    input  req, addr, we, wdata, wstrb,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master / one-slave memory port arbiter. Round-robin selection, the
// selection is held while the slave stalls, and an in-order tag queue
// routes each response back to the master that issued the transaction.
module mem_port_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int OUTSTANDING = 2,
  parameter int PTR_LENGTH  = 2
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave  m0,
  mem_port_arbiter_if.slave  m1,
  mem_port_arbiter_if.master s,
  output logic err_orphan
);
  typedef enum logic {IDLE, HOLD} state_t;

  localparam int IW = PTR_LENGTH - 1;

  state_t                  state_q, state_d;
  logic                    last_gnt_q, last_gnt_d;
  logic                    hold_sel_q, hold_sel_d;
  logic [OUTSTANDING-1:0]  tag_q, tag_d;
  logic [PTR_LENGTH-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic                    err_q, err_d;

  logic                    full, empty;
  logic                    sel, s_req, accept, pop, rtag;
  logic [DATA_WIDTH-1:0]   rdata_fwd;

  // Queue status from the wrap-bit pointer pair
  always_comb begin
    full  = (wptr_q[IW-1:0] == rptr_q[IW-1:0]) && (wptr_q[IW] != rptr_q[IW]);
    empty = (wptr_q == rptr_q);
  end

  // Master selection: round-robin in IDLE, frozen in HOLD, m0 during reset
  always_comb begin
    sel   = 1'b0;
    s_req = 1'b0;
    if (!rst) begin
      if (state_q == HOLD) begin
        sel   = hold_sel_q;
        s_req = ~full;
      end else begin
        // Tie goes to whoever was not granted last; otherwise the lone requester
        if (m0.req && m1.req) sel = ~last_gnt_q;
        else                  sel = m1.req;
        s_req = (sel ? m1.req : m0.req) & ~full;
      end
    end
  end

  assign accept = s_req & s.gnt;
  assign rtag   = tag_q[rptr_q[IW-1:0]];
  // Response pops only with an owner on record; reset suppresses routing
  assign pop    = s.rvalid & ~empty & ~rst;

  assign s.req   = s_req;
  assign s.addr  = sel ? m1.addr  : m0.addr;
  assign s.we    = sel ? m1.we    : m0.we;
  assign s.wdata = sel ? m1.wdata : m0.wdata;
  assign s.wstrb = sel ? m1.wstrb : m0.wstrb;

  assign rdata_fwd = s.rdata;
  assign m0.rdata  = rdata_fwd;
  assign m1.rdata  = rdata_fwd;
  assign m0.gnt    = accept & ~sel;
  assign m1.gnt    = accept &  sel;
  assign m0.rvalid = pop & ~rtag;
  assign m1.rvalid = pop &  rtag;

  assign err_orphan = err_q;

  // Next-state: FSM, round-robin history, tag queue push/pop, orphan flag
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    hold_sel_d = hold_sel_q;
    tag_d      = tag_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    err_d      = err_q;

    if (accept) begin
      tag_d[wptr_q[IW-1:0]] = sel;
      wptr_d                = wptr_q + PTR_LENGTH'(1);
      last_gnt_d            = sel;
    end
    if (pop)                 rptr_d = rptr_q + PTR_LENGTH'(1);
    if (s.rvalid && empty)   err_d  = 1'b1;

    case (state_q)
      IDLE: if (s_req && !s.gnt) begin
        state_d    = HOLD;
        hold_sel_d = sel;
      end
      HOLD: if (accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      hold_sel_q <= 1'b0;
      tag_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      hold_sel_q <= hold_sel_d;
      tag_q      <= tag_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle-by-cycle vector table plus
// hand sequences for stall hold, reset during HOLD and pointer wrap.
module tb_mem_port_arbiter;
  localparam int DW = 32;
  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h0000_2000;

  logic clk = 1'b0;
  logic rst;
  logic err_orphan;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DATA_WIDTH(DW)) m0_if ();
  mem_port_arbiter_if #(.DATA_WIDTH(DW)) m1_if ();
  mem_port_arbiter_if #(.DATA_WIDTH(DW)) s_if ();

  mem_port_arbiter #(.DATA_WIDTH(DW), .OUTSTANDING(2), .PTR_LENGTH(2)) dut (
    .clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if), .s(s_if), .err_orphan(err_orphan)
  );

  typedef struct packed {
    logic        rst, m0r, m1r, sg, rv;
    logic [31:0] rdata;
    logic        g0, g1, sreq, rv0, rv1, err;
    logic [31:0] saddr;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t v(input logic r, a, b, g, rv, input logic [31:0] d,
                             input logic e0, e1, er, ev0, ev1, ee, input logic [31:0] ea);
    vec_t t;
    t = '{r, a, b, g, rv, d, e0, e1, er, ev0, ev1, ee, ea};
    return t;
  endfunction

  task automatic drive(input logic r, a, b, g, rv, input logic [31:0] d);
    @(negedge clk);
    rst = r; m0_if.req = a; m1_if.req = b;
    s_if.gnt = g; s_if.rvalid = rv; s_if.rdata = d;
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] obs();
    return {m0_if.gnt, m1_if.gnt, s_if.req, m0_if.rvalid, m1_if.rvalid, err_orphan};
  endfunction

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    m0_if.req = 0; m0_if.addr = A0; m0_if.we = 0; m0_if.wdata = 32'hA0; m0_if.wstrb = 4'hF;
    m1_if.req = 0; m1_if.addr = A1; m1_if.we = 1; m1_if.wdata = 32'hB0; m1_if.wstrb = 4'h3;
    s_if.gnt = 0; s_if.rvalid = 0; s_if.rdata = 0;

    //           rst m0 m1 sg rv rdata    g0 g1 sq r0 r1 er addr
    tbl[0]  = v(1, 1, 1, 1, 0, 32'h0,   0, 0, 0, 0, 0, 0, A0);
    tbl[1]  = v(0, 1, 1, 1, 0, 32'h0,   1, 0, 1, 0, 0, 0, A0);
    tbl[2]  = v(0, 1, 1, 1, 1, 32'hA,   0, 1, 1, 1, 0, 0, A1);
    tbl[3]  = v(0, 1, 1, 1, 1, 32'hB,   1, 0, 1, 0, 1, 0, A0);
    tbl[4]  = v(0, 0, 0, 0, 1, 32'hC,   0, 0, 0, 1, 0, 0, A0);
    tbl[5]  = v(0, 0, 0, 0, 1, 32'h0,   0, 0, 0, 0, 0, 0, A0);
    tbl[6]  = v(0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0, 0, 1, A0);
    tbl[7]  = v(0, 1, 0, 1, 0, 32'h0,   1, 0, 1, 0, 0, 1, A0);
    tbl[8]  = v(0, 1, 0, 1, 0, 32'h0,   1, 0, 1, 0, 0, 1, A0);
    tbl[9]  = v(0, 1, 0, 1, 0, 32'h0,   0, 0, 0, 0, 0, 1, A0);
    tbl[10] = v(0, 1, 0, 1, 1, 32'hD,   0, 0, 0, 1, 0, 1, A0);
    tbl[11] = v(0, 1, 0, 1, 0, 32'h0,   1, 0, 1, 0, 0, 1, A0);
    tbl[12] = v(0, 0, 0, 0, 1, 32'hE,   0, 0, 0, 1, 0, 1, A0);
    tbl[13] = v(0, 0, 0, 0, 1, 32'hF,   0, 0, 0, 1, 0, 1, A0);
    tbl[14] = v(0, 1, 0, 1, 0, 32'h0,   1, 0, 1, 0, 0, 1, A0);
    tbl[15] = v(0, 0, 1, 1, 0, 32'h0,   0, 1, 1, 0, 0, 1, A1);
    tbl[16] = v(0, 1, 0, 1, 1, 32'hA,   0, 0, 0, 1, 0, 1, A0);
    tbl[17] = v(0, 1, 0, 1, 1, 32'hB,   1, 0, 1, 0, 1, 1, A0);
    tbl[18] = v(0, 0, 0, 0, 1, 32'hC,   0, 0, 0, 1, 0, 1, A0);
    tbl[19] = v(1, 1, 1, 1, 1, 32'h0,   0, 0, 0, 0, 0, 1, A0);
    tbl[20] = v(0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0, 0, 0, A0);

    do_reset();
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].rst, tbl[i].m0r, tbl[i].m1r, tbl[i].sg, tbl[i].rv, tbl[i].rdata);
      chk($sformatf("vec%0d ctl", i), {26'd0, obs()},
          {26'd0, tbl[i].g0, tbl[i].g1, tbl[i].sreq, tbl[i].rv0, tbl[i].rv1, tbl[i].err});
      chk($sformatf("vec%0d s_addr", i), s_if.addr, tbl[i].saddr);
      chk($sformatf("vec%0d s_we", i), {31'd0, s_if.we}, {31'd0, tbl[i].saddr == A1});
      if (tbl[i].rv0) chk($sformatf("vec%0d m0_rdata", i), m0_if.rdata, tbl[i].rdata);
      if (tbl[i].rv1) chk($sformatf("vec%0d m1_rdata", i), m1_if.rdata, tbl[i].rdata);
    end

    // Slave stall: m1 held for three cycles even after m0 starts requesting
    do_reset();
    drive(0, 0, 1, 0, 0, 0); chk("hold c1", {26'd0, obs()}, 32'b001000); chk("hold c1 addr", s_if.addr, A1);
    drive(0, 1, 1, 0, 0, 0); chk("hold c2", {26'd0, obs()}, 32'b001000); chk("hold c2 addr", s_if.addr, A1);
    drive(0, 1, 1, 0, 0, 0); chk("hold c3", {26'd0, obs()}, 32'b001000); chk("hold c3 addr", s_if.addr, A1);
    drive(0, 1, 1, 1, 0, 0); chk("hold c4", {26'd0, obs()}, 32'b011000); chk("hold c4 addr", s_if.addr, A1);
    drive(0, 1, 0, 1, 0, 0); chk("hold c5", {26'd0, obs()}, 32'b101000); chk("hold c5 addr", s_if.addr, A0);

    // Reset while in HOLD with a transaction outstanding
    do_reset();
    drive(0, 1, 0, 1, 0, 0); chk("rsth acc", {26'd0, obs()}, 32'b101000);
    drive(0, 0, 1, 0, 0, 0); chk("rsth stall", {26'd0, obs()}, 32'b001000);
    drive(1, 0, 1, 0, 0, 0); chk("rsth in rst", {26'd0, obs()}, 32'b000000);
    chk("rsth rst addr", s_if.addr, A0);
    drive(0, 0, 0, 0, 1, 0); chk("rsth orphan", {26'd0, obs()}, 32'b000000);
    drive(0, 1, 1, 1, 0, 0); chk("rsth idle", {26'd0, obs()}, 32'b101001);
    chk("rsth idle addr", s_if.addr, A0);

    // Simultaneous accept+response with one entry in flight; pointers wrap
    do_reset();
    drive(0, 1, 0, 1, 0, 0); chk("wrap prime", {26'd0, obs()}, 32'b101000);
    for (int i = 1; i <= 8; i++) begin
      logic m, p;
      m = logic'(i % 2);
      p = logic'((i - 1) % 2);
      drive(0, !m, m, 1, 1, 32'(i));
      chk($sformatf("wrap%0d ctl", i), {26'd0, obs()}, {26'd0, !m, m, 1'b1, !p, p, 1'b0});
      chk($sformatf("wrap%0d rdata", i), p ? m1_if.rdata : m0_if.rdata, 32'(i));
    end
    drive(0, 0, 0, 0, 1, 32'h9); chk("wrap drain", {26'd0, obs()}, 32'b000100);
    drive(0, 0, 0, 0, 0, 0);     chk("wrap end", {26'd0, obs()}, 32'b000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-master, one-slave arbiter placed between the instruction-fetch unit (master 0) and the load/store unit (master 1) on the core's single memory port. It selects one request per cycle with round-robin fairness. It holds the selection stable while the slave stalls. An internal in-order tag queue records which master owns each accepted transaction, so read responses are routed back to the correct master.

## Interface
- DATA_WIDTH, 32, width of address and data buses
- OUTSTANDING, 2, maximum accepted-but-unanswered transactions; power of 2, ≥2
- PTR_LENGTH, 2, tag-queue pointer width; equals log2(OUTSTANDING)+1 (extra wrap bit)
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- m0_req / m1_req  in  1  master request valid
- m0_addr / m1_addr  in  DATA_WIDTH  byte address
- m0_we / m1_we  in  1  1 = write
- m0_wdata / m1_wdata  in  DATA_WIDTH  write data
- m0_wstrb / m1_wstrb  in  4  byte strobes
- m0_gnt / m1_gnt  out  1  request accepted this cycle
- m0_rvalid / m1_rvalid  out  1  response valid, one cycle
- m0_rdata / m1_rdata  out  DATA_WIDTH  response data, both driven from s_rdata
- s_req  out  1  slave request valid
- s_addr, s_wdata  out  DATA_WIDTH  muxed from the selected master
- s_we  out  1  muxed from the selected master
- s_wstrb  out  4  muxed from the selected master
- s_gnt  in  1  slave accepts s_req this cycle
- s_rvalid  in  1  slave response, one per accepted transaction, in order, writes included
- s_rdata  in  DATA_WIDTH  response data
- err_orphan  out  1  sticky; set when s_rvalid arrives with the tag queue empty

## Operation
- Registers:
  - last_gnt: 1 bit; reset value 1, so m0 wins the first tie.
  - State: IDLE or HOLD; reset value IDLE.
  - hold_sel: 1 bit.
  - Tag queue: OUTSTANDING x 1 bit, with wptr/rptr of PTR_LENGTH bits.
  - err_orphan.
- Queue full condition: low pointer bits equal and MSBs differ. Queue empty condition: low pointer bits equal and MSBs equal.
- IDLE, selection:
  - Only one master requesting: that master is selected.
  - Both masters requesting: the master ≠ last_gnt is selected.
  - s_req = selected master's req AND NOT full.
- HOLD, selection:
  - sel = hold_sel. Other-master requests are ignored.
  - s_req = 1 AND NOT full.
- Transitions:
  - IDLE→HOLD when s_req=1 and s_gnt=0. hold_sel ← sel.
  - HOLD→IDLE when s_req & s_gnt.
  - Otherwise the state holds.
- Masters must keep req/addr/data stable until granted. The arbiter does not check this.
- Accept event = s_req & s_gnt. On accept:
  - m<sel>_gnt = 1, combinational in the same cycle.
  - Tag sel is pushed at wptr, then wptr+1.
  - last_gnt ← sel.
- Response event = s_rvalid.
  - Queue not empty: m<tag[rptr]>_rvalid = 1 in the same cycle, then rptr+1.
  - Queue empty: both rvalids stay 0, err_orphan ← 1, pointers unchanged.
- Simultaneous accept and response: push and pop both occur. Count is unchanged.
- Full queue with a same-cycle response: s_req stays 0 that cycle. Push is never allowed on full, even when a pop happens in the same cycle.
- Pointers wrap naturally modulo 2^PTR_LENGTH.

## Timing
- Outputs that are combinational in the cycle of the event: grant, s_* mux, rvalid routing. No added latency.
- Registered state updates on the clk edge: state, last_gnt, hold_sel, pointers, err_orphan.
- Back-to-back accepts every cycle are allowed until the queue is full. Sustained throughput is 1 transaction/cycle when the slave returns responses within OUTSTANDING cycles.
- Reset takes effect on the first rising edge with rst=1, including mid-transaction. Values after that edge:
  - State IDLE, last_gnt=1, pointers 0, err_orphan 0.
  - Outstanding tags are discarded. A later s_rvalid sets err_orphan.
- Outputs while rst=1:
  - s_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid all forced 0.
  - s_addr, s_wdata, s_we, s_wstrb carry m0 values.

## Test plan
- Reset, then both req=1 with s_gnt=1. Required: cycle 0 grants m0 and cycle 1 grants m1; grants alternate while both keep requesting.
- m1 alone, s_gnt=0 for 3 cycles, m0 raising req in the 2nd cycle. Required: s_addr stays at m1_addr and the FSM stays in HOLD; m1_gnt pulses in cycle 4; m0 is granted in cycle 5.
- OUTSTANDING=2, three m0 accepts with no s_rvalid. Required: the 3rd request sees s_req=0. After one s_rvalid, m0_rvalid=1 and the 3rd is accepted the next cycle.
- Accept order m0, m1, m0, then 3 s_rvalid with rdata 0xA, 0xB, 0xC. Required: m0_rvalid with 0xA, m1_rvalid with 0xB, m0_rvalid with 0xC.
- Queue holds 1 entry; accept and s_rvalid in the same cycle. Required: count stays 1, the tag is routed correctly, and pointers wrap past 3→0 over 8 transactions.
- s_rvalid with the queue empty. Required: no rvalid output and err_orphan=1 until rst. Also: rst during HOLD with 2 outstanding returns to IDLE with empty queue.
